semaforo: RTL and testbench

Two-way traffic-light controller for crossing roads A and B, with a request button for road B. Road A's green, yellow and red phase lengths are set by cycle-count parameters. The block sits between the system clock/reset and the lamp drivers of both signal heads. It drives one-hot lamp codes from a registered Moore state machine.

---
 rtl/semaforo.sv | 112 +++++++++++
 tb/tb_semaforo.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/semaforo.sv
// Two-way traffic-light controller for roads A and B with a road-B request button.
// Registered Moore FSM with an 8-bit phase down-counter and a held request latch.
module semaforo #(
    parameter logic [7:0] VERDE    = 8'd1,
    parameter logic [7:0] AMARELO  = 8'd3,
    parameter logic [7:0] VERMELHO = 8'd2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bt,
    output logic [2:0] A,
    output logic [2:0] B
);

    localparam logic [1:0] ST_AG = 2'b00;
    localparam logic [1:0] ST_AY = 2'b01;
    localparam logic [1:0] ST_AR = 2'b10;

    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_RED    = 3'b100;

    localparam logic [7:0] LOAD_AG = VERDE    - 8'd1;
    localparam logic [7:0] LOAD_AY = AMARELO  - 8'd1;
    localparam logic [7:0] LOAD_AR = VERMELHO - 8'd1;

    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       req_q, req_d;
    logic [2:0] a_q, a_d;
    logic [2:0] b_q, b_d;
    logic       cnt_zero;

    assign cnt_zero = (cnt_q == 8'd0);

    // A bt seen on the AY->AR edge survives the clear, so it shortens the next green.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - 8'd1;
        req_d   = req_q | bt;
        case (state_q)
            ST_AG: begin
                if (cnt_zero || req_q || bt) begin
                    state_d = ST_AY;
                    cnt_d   = LOAD_AY;
                end
            end
            ST_AY: begin
                if (cnt_zero) begin
                    state_d = ST_AR;
                    cnt_d   = LOAD_AR;
                    req_d   = bt;
                end
            end
            ST_AR: begin
                if (cnt_zero) begin
                    state_d = ST_AG;
                    cnt_d   = LOAD_AG;
                end
            end
            default: begin
                state_d = ST_AG;
                cnt_d   = LOAD_AG;
                req_d   = 1'b0;
            end
        endcase
    end

    // Lamps are decoded from the next state so the outputs come straight from flops.
    always_comb begin
        a_d = LAMP_GREEN;
        b_d = LAMP_RED;
        case (state_d)
            ST_AG: begin
                a_d = LAMP_GREEN;
                b_d = LAMP_RED;
            end
            ST_AY: begin
                a_d = LAMP_YELLOW;
                b_d = LAMP_RED;
            end
            ST_AR: begin
                a_d = LAMP_RED;
                b_d = (cnt_d == 8'd0) ? LAMP_YELLOW : LAMP_GREEN;
            end
            default: begin
                a_d = LAMP_GREEN;
                b_d = LAMP_RED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_AG;
            cnt_q   <= LOAD_AG;
            req_q   <= 1'b0;
            a_q     <= LAMP_GREEN;
            b_q     <= LAMP_RED;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign A = a_q;
    assign B = b_q;

endmodule

// File: tb/tb_semaforo.sv
// Directed bench for semaforo: defaults, long green, request handling, reset, boundaries.
module tb_semaforo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_def, rst_long, rst_bnd, rst_max;
    logic bt_def, bt_long, bt_bnd, bt_max;
    logic [2:0] a_def, b_def, a_long, b_long, a_bnd, b_bnd, a_max, b_max;

    int total = 0;
    int bad   = 0;

    semaforo u_def (
        .clk(clk), .rst(rst_def), .bt(bt_def), .A(a_def), .B(b_def)
    );

    semaforo #(.VERDE(8'd8), .AMARELO(8'd3), .VERMELHO(8'd2)) u_long (
        .clk(clk), .rst(rst_long), .bt(bt_long), .A(a_long), .B(b_long)
    );

    semaforo #(.VERDE(8'd1), .AMARELO(8'd1), .VERMELHO(8'd1)) u_bnd (
        .clk(clk), .rst(rst_bnd), .bt(bt_bnd), .A(a_bnd), .B(b_bnd)
    );

    semaforo #(.VERDE(8'd255), .AMARELO(8'd255), .VERMELHO(8'd255)) u_max (
        .clk(clk), .rst(rst_max), .bt(bt_max), .A(a_max), .B(b_max)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_long(input string tag, input logic [2:0] ea, input logic [2:0] eb);
        check({tag, ".A"}, a_long, ea);
        check({tag, ".B"}, b_long, eb);
    endtask

    logic [2:0] seq_a [6];
    logic [2:0] seq_b [6];
    logic [2:0] ea, eb;

    initial begin
        seq_a = '{3'b010, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};
        seq_b = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
        rst_def = 0; rst_long = 0; rst_bnd = 0; rst_max = 0;
        bt_def = 0; bt_long = 0; bt_bnd = 0; bt_max = 0;
        tick();
        tick();

        // Reset state and default 6-cycle period
        check("def_reset.A", a_def, 3'b001);
        check("def_reset.B", b_def, 3'b100);
        rst_def = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("def_seq%0d.A", i), a_def, seq_a[i % 6]);
            check($sformatf("def_seq%0d.B", i), b_def, seq_b[i % 6]);
            $display("def cycle %0d A=%b B=%b", i, a_def, b_def);
        end

        // VERDE=8: full green of 8 cycles, AY 3, AR 2
        check_long("long_reset", 3'b001, 3'b100);
        rst_long = 1;
        for (int i = 0; i < 7; i++) begin tick(); check_long("long_ag", 3'b001, 3'b100); end
        for (int i = 0; i < 3; i++) begin tick(); check_long("long_ay", 3'b010, 3'b100); end
        tick(); check_long("long_ar1", 3'b100, 3'b001);
        tick(); check_long("long_ar2", 3'b100, 3'b010);
        tick(); check_long("long_ag1", 3'b001, 3'b100);
        $display("long: full green period done");

        // bt pulse at AG cycle 3 ends green on the next edge
        tick(); check_long("btag_c2", 3'b001, 3'b100);
        tick(); check_long("btag_c3", 3'b001, 3'b100);
        bt_long = 1;
        tick(); check_long("btag_ay1", 3'b010, 3'b100);
        bt_long = 0;
        tick(); check_long("btag_ay2", 3'b010, 3'b100);
        tick(); check_long("btag_ay3", 3'b010, 3'b100);
        tick(); check_long("btag_ar1", 3'b100, 3'b001);
        tick(); check_long("btag_ar2", 3'b100, 3'b010);
        tick(); check_long("btag_nextag1", 3'b001, 3'b100);
        for (int i = 0; i < 7; i++) begin tick(); check_long("btag_nextag", 3'b001, 3'b100); end
        tick(); check_long("btag_nextay1", 3'b010, 3'b100);
        $display("long: bt in AG shortened green to 3, next green full");

        // Request during AR shortens the following AG to one cycle only
        tick(); check_long("rqar_ay2", 3'b010, 3'b100);
        tick(); check_long("rqar_ay3", 3'b010, 3'b100);
        tick(); check_long("rqar_ar1", 3'b100, 3'b001);
        bt_long = 1;
        tick(); check_long("rqar_ar2", 3'b100, 3'b010);
        bt_long = 0;
        tick(); check_long("rqar_ag1", 3'b001, 3'b100);
        tick(); check_long("rqar_ay1", 3'b010, 3'b100);
        tick(); check_long("rqar_ay2b", 3'b010, 3'b100);
        tick(); check_long("rqar_ay3b", 3'b010, 3'b100);
        tick(); check_long("rqar_ar1b", 3'b100, 3'b001);
        tick(); check_long("rqar_ar2b", 3'b100, 3'b010);
        tick(); check_long("rqar_fullag1", 3'b001, 3'b100);
        for (int i = 0; i < 7; i++) begin tick(); check_long("rqar_fullag", 3'b001, 3'b100); end
        tick(); check_long("rqar_fullay1", 3'b010, 3'b100);
        $display("long: AR request gave 1-cycle green, then full green");

        // Reset during AY cycle 2 with a pending request
        tick(); check_long("rmid_ay2", 3'b010, 3'b100);
        tick(); check_long("rmid_ay3", 3'b010, 3'b100);
        tick(); check_long("rmid_ar1", 3'b100, 3'b001);
        tick(); check_long("rmid_ar2", 3'b100, 3'b010);
        tick(); check_long("rmid_ag1", 3'b001, 3'b100);
        bt_long = 1;
        tick(); check_long("rmid_pay1", 3'b010, 3'b100);
        bt_long = 0;
        tick(); check_long("rmid_pay2", 3'b010, 3'b100);
        rst_long = 0;
        tick(); check_long("rmid_reset", 3'b001, 3'b100);
        rst_long = 1;
        for (int i = 0; i < 7; i++) begin tick(); check_long("rmid_ag", 3'b001, 3'b100); end
        tick(); check_long("rmid_ay1", 3'b010, 3'b100);
        $display("long: mid-phase reset restarted full green, request dropped");

        // All lengths 1: period of 3, B never green
        check("bnd_reset.A", a_bnd, 3'b001);
        check("bnd_reset.B", b_bnd, 3'b100);
        rst_bnd = 1;
        for (int i = 0; i < 9; i++) begin
            tick();
            case (i % 3)
                0: begin ea = 3'b010; eb = 3'b100; end
                1: begin ea = 3'b100; eb = 3'b010; end
                default: begin ea = 3'b001; eb = 3'b100; end
            endcase
            check($sformatf("bnd%0d.A", i), a_bnd, ea);
            check($sformatf("bnd%0d.B", i), b_bnd, eb);
            $display("bnd cycle %0d A=%b B=%b", i, a_bnd, b_bnd);
        end

        // All lengths 255: one full period plus a few cycles, checked each cycle
        rst_max = 1;
        for (int k = 1; k <= 770; k++) begin
            tick();
            if (k < 255) begin ea = 3'b001; eb = 3'b100; end
            else if (k < 510) begin ea = 3'b010; eb = 3'b100; end
            else if (k < 764) begin ea = 3'b100; eb = 3'b001; end
            else if (k == 764) begin ea = 3'b100; eb = 3'b010; end
            else begin ea = 3'b001; eb = 3'b100; end
            check($sformatf("max%0d.A", k), a_max, ea);
            check($sformatf("max%0d.B", k), b_max, eb);
        end
        $display("max: 770 cycles checked");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
